// File: rtl/calc_entry_ctrl.sv
// Keypad entry sequencer for the floating-point calculator.
// Assembles operand A, operator and operand B as BCD digits with decimal-point
// counts, starts the arithmetic unit, waits for done/timeout, and drives the
// display word. All outputs are registered.
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   key_value/key_valid decoded key code and key-present level (rising edge = event)
//   clear               synchronous clear, active-high
//   done, result_*      arithmetic unit completion pulse and result payload
//   op_a/dp_a/op_b/dp_b operands (newest digit in [3:0]) and digits after point
//   opcode              00 add, 01 sub, 10 mul, 11 div
//   start, busy, error  arithmetic start pulse, CALC flag, ERROR flag
//   display             word for the 7-segment driver
module calc_entry_ctrl #(
   parameter int unsigned DIGITS  = 5,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [3:0]            key_value,
   input  logic                  key_valid,
   input  logic                  clear,
   input  logic                  done,
   input  logic [DIGITS*4-1:0]   result_bcd,
   input  logic [3:0]            result_dp,
   input  logic                  result_err,
   output logic [DIGITS*4-1:0]   op_a,
   output logic [3:0]            dp_a,
   output logic [DIGITS*4-1:0]   op_b,
   output logic [3:0]            dp_b,
   output logic [1:0]            opcode,
   output logic                  start,
   output logic                  busy,
   output logic                  error,
   output logic [DIGITS*4-1:0]   display
);

   localparam int unsigned DW = DIGITS * 4;
   localparam int unsigned CW = $clog2(DIGITS + 1);
   localparam int unsigned TW = $clog2(TIMEOUT);

   typedef enum logic [2:0] {
      ENTER_A = 3'd0,
      ENTER_B = 3'd1,
      CALC    = 3'd2,
      RESULT  = 3'd3,
      ERROR   = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic            key_prev_q;
   logic [CW-1:0]   cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
   logic            dot_a_q, dot_a_d, dot_b_q, dot_b_d;
   logic [TW-1:0]   tcnt_q, tcnt_d;
   logic [DW-1:0]   res_bcd_q, res_bcd_d;
   logic [3:0]      res_dp_q, res_dp_d;

   logic [DW-1:0]   op_a_d, op_b_d, display_d;
   logic [3:0]      dp_a_d, dp_b_d;
   logic [1:0]      opcode_d;
   logic            start_d, busy_d, error_d;

   // Key classification; an event is a rising edge of key_valid
   logic            key_event;
   logic            is_digit, is_op, is_dot, is_eq;
   logic [1:0]      key_opcode;

   assign key_event  = key_valid & ~key_prev_q;
   assign is_digit   = (key_value <= 4'd9);
   assign is_op      = (key_value >= 4'hA) && (key_value <= 4'hD);
   assign is_dot     = (key_value == 4'hE);
   assign is_eq      = (key_value == 4'hF);
   assign key_opcode = 2'(key_value - 4'hA);

   // Next-state and next-output logic
   always_comb begin
      state_d   = state_q;
      cnt_a_d   = cnt_a_q;
      cnt_b_d   = cnt_b_q;
      dot_a_d   = dot_a_q;
      dot_b_d   = dot_b_q;
      tcnt_d    = tcnt_q;
      res_bcd_d = res_bcd_q;
      res_dp_d  = res_dp_q;
      op_a_d    = op_a;
      dp_a_d    = dp_a;
      op_b_d    = op_b;
      dp_b_d    = dp_b;
      opcode_d  = opcode;
      start_d   = 1'b0;
      busy_d    = 1'b0;
      error_d   = 1'b0;
      display_d = display;

      case (state_q)
         ENTER_A: begin
            if (key_event) begin
               if (is_digit) begin
                  if (cnt_a_q < CW'(DIGITS)) begin
                     op_a_d  = {op_a[DW-5:0], key_value};
                     cnt_a_d = cnt_a_q + CW'(1);
                     if (dot_a_q) dp_a_d = dp_a + 4'd1;
                  end
               end else if (is_dot) begin
                  if (!dot_a_q && (cnt_a_q < CW'(DIGITS))) dot_a_d = 1'b1;
               end else if (is_op) begin
                  if (cnt_a_q != '0) begin
                     opcode_d = key_opcode;
                     state_d  = ENTER_B;
                  end
               end
            end
         end

         ENTER_B: begin
            if (key_event) begin
               if (is_digit) begin
                  if (cnt_b_q < CW'(DIGITS)) begin
                     op_b_d  = {op_b[DW-5:0], key_value};
                     cnt_b_d = cnt_b_q + CW'(1);
                     if (dot_b_q) dp_b_d = dp_b + 4'd1;
                  end
               end else if (is_dot) begin
                  if (!dot_b_q && (cnt_b_q < CW'(DIGITS))) dot_b_d = 1'b1;
               end else if (is_op) begin
                  if (cnt_b_q == '0) opcode_d = key_opcode;
               end else if (is_eq) begin
                  if (cnt_b_q != '0) begin
                     state_d = CALC;
                     tcnt_d  = '0;
                     start_d = 1'b1;
                  end
               end
            end
         end

         // Keys are ignored here; done takes priority over the timeout
         CALC: begin
            if (done) begin
               if (result_err) begin
                  state_d = ERROR;
               end else begin
                  res_bcd_d = result_bcd;
                  res_dp_d  = result_dp;
                  state_d   = RESULT;
               end
            end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
               state_d = ERROR;
            end else begin
               tcnt_d = tcnt_q + TW'(1);
            end
         end

         // A digit or dot starts fresh entry; an operator chains on the result
         RESULT: begin
            if (key_event && !is_eq) begin
               op_b_d  = '0;
               dp_b_d  = '0;
               cnt_b_d = '0;
               dot_b_d = 1'b0;
               if (is_digit) begin
                  op_a_d  = DW'(key_value);
                  dp_a_d  = '0;
                  cnt_a_d = CW'(1);
                  dot_a_d = 1'b0;
                  state_d = ENTER_A;
               end else if (is_dot) begin
                  op_a_d  = '0;
                  dp_a_d  = '0;
                  cnt_a_d = '0;
                  dot_a_d = 1'b1;
                  state_d = ENTER_A;
               end else begin
                  op_a_d   = res_bcd_q;
                  dp_a_d   = res_dp_q;
                  cnt_a_d  = CW'(DIGITS);
                  dot_a_d  = (res_dp_q != 4'd0);
                  opcode_d = key_opcode;
                  state_d  = ENTER_B;
               end
            end
         end

         ERROR: begin
         end

         default: state_d = ENTER_A;
      endcase

      // Clear overrides every other event in the same cycle
      if (clear) begin
         state_d   = ENTER_A;
         cnt_a_d   = '0;
         cnt_b_d   = '0;
         dot_a_d   = 1'b0;
         dot_b_d   = 1'b0;
         tcnt_d    = '0;
         res_bcd_d = '0;
         res_dp_d  = '0;
         op_a_d    = '0;
         dp_a_d    = '0;
         op_b_d    = '0;
         dp_b_d    = '0;
         opcode_d  = '0;
         start_d   = 1'b0;
      end

      busy_d  = (state_d == CALC);
      error_d = (state_d == ERROR);

      // Display follows the state being entered
      case (state_d)
         ENTER_A: display_d = op_a_d;
         ENTER_B: display_d = (cnt_b_d != '0) ? op_b_d : op_a_d;
         RESULT:  display_d = res_bcd_d;
         ERROR:   display_d = {DIGITS{4'hE}};
         default: display_d = display;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ENTER_A;
         key_prev_q <= 1'b0;
         cnt_a_q    <= '0;
         cnt_b_q    <= '0;
         dot_a_q    <= 1'b0;
         dot_b_q    <= 1'b0;
         tcnt_q     <= '0;
         res_bcd_q  <= '0;
         res_dp_q   <= '0;
         op_a       <= '0;
         dp_a       <= '0;
         op_b       <= '0;
         dp_b       <= '0;
         opcode     <= '0;
         start      <= 1'b0;
         busy       <= 1'b0;
         error      <= 1'b0;
         display    <= '0;
      end else begin
         state_q    <= state_d;
         key_prev_q <= key_valid;
         cnt_a_q    <= cnt_a_d;
         cnt_b_q    <= cnt_b_d;
         dot_a_q    <= dot_a_d;
         dot_b_q    <= dot_b_d;
         tcnt_q     <= tcnt_d;
         res_bcd_q  <= res_bcd_d;
         res_dp_q   <= res_dp_d;
         op_a       <= op_a_d;
         dp_a       <= dp_a_d;
         op_b       <= op_b_d;
         dp_b       <= dp_b_d;
         opcode     <= opcode_d;
         start      <= start_d;
         busy       <= busy_d;
         error      <= error_d;
         display    <= display_d;
      end
   end

endmodule
